// File: rtl/ram_lsu_port.sv
// LSU-side initiator for one port of the byte-masked data RAM: byte-addressed sized requests in,
// word-addressed RAM accesses out, aligned and extended responses back with one response outstanding.
//
// state | meaning
// IDLE  | no response pending
// RESP  | response presented from live ram_dout, the cycle after acceptance
// HOLD  | response presented from the capture register while the consumer stalls
module ram_lsu_port #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_vld,
   output logic              req_rdy,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_wdata,
   output logic              rsp_vld,
   input  logic              rsp_rdy,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [3:0]        ram_wem,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RESP = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        misaligned;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic        we_q;
   logic        err_q;
   logic [31:0] hold_rdata;
   logic        hold_err;
   logic [31:0] shifted;
   logic [31:0] fmt_rdata;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

   // req_rdy is combinational from rsp_rdy so a consumed response can overlap the next accept
   assign req_rdy = rst_n & ((state == IDLE) | rsp_rdy);
   assign accept  = req_vld & req_rdy;

   assign misaligned = ((req_size == 2'd1) & req_addr[0])
                     | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00))
                     | (req_size == 2'd3);

   always_comb begin
      ram_en   = accept & ~misaligned;
      ram_we   = ram_en & req_we;
      ram_addr = req_addr[ADDR_W+1:2];
      ram_din  = req_wdata;
      ram_wem  = 4'b0000;
      case (req_size)
         2'd0: begin
            ram_din = {4{req_wdata[7:0]}};
            ram_wem = 4'b0001 << req_addr[1:0];
         end
         2'd1: begin
            ram_din = {2{req_wdata[15:0]}};
            ram_wem = 4'b0011 << req_addr[1:0];
         end
         default: begin
            ram_din = req_wdata;
            ram_wem = 4'b1111;
         end
      endcase
      if (!ram_we)
         ram_wem = 4'b0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off_q  <= 2'd0;
         size_q <= 2'd0;
         uns_q  <= 1'b0;
         we_q   <= 1'b0;
         err_q  <= 1'b0;
      end else if (accept) begin
         off_q  <= req_addr[1:0];
         size_q <= req_size;
         uns_q  <= req_unsigned;
         we_q   <= req_we;
         err_q  <= misaligned;
      end
   end

   always_comb begin
      shifted   = ram_dout >> {off_q, 3'b000};
      fmt_rdata = shifted;
      case (size_q)
         2'd0:    fmt_rdata = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
         2'd1:    fmt_rdata = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
         default: fmt_rdata = shifted;
      endcase
      if (we_q | err_q)
         fmt_rdata = 32'd0;
   end

   // ram_dout is only trustworthy in RESP, so a stalled response is frozen here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_rdata <= 32'd0;
         hold_err   <= 1'b0;
      end else if ((state == RESP) && !rsp_rdy) begin
         hold_rdata <= fmt_rdata;
         hold_err   <= err_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = RESP;
         RESP, HOLD: begin
            if (rsp_rdy)
               state_nxt = accept ? RESP : IDLE;
            else
               state_nxt = HOLD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rsp_vld   = 1'b0;
      rsp_rdata = 32'd0;
      rsp_err   = 1'b0;
      case (state)
         RESP: begin
            rsp_vld   = 1'b1;
            rsp_rdata = fmt_rdata;
            rsp_err   = err_q;
         end
         HOLD: begin
            rsp_vld   = 1'b1;
            rsp_rdata = hold_rdata;
            rsp_err   = hold_err;
         end
         default: begin
            rsp_vld   = 1'b0;
            rsp_rdata = 32'd0;
            rsp_err   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_ram_lsu_port.sv
// Scoreboard bench for ram_lsu_port: a byte-array reference memory predicts every response,
// and a negedge monitor checks responses, latency and stall stability.
module tb_ram_lsu_port;
   localparam int ADDR_W = 8;
   localparam int NW     = 1 << ADDR_W;
   localparam int NB     = NW * 4;

   logic              clk;
   logic              rst_n;
   logic              req_vld;
   logic              req_rdy;
   logic              req_we;
   logic [31:0]       req_addr;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_wdata;
   logic              rsp_vld;
   logic              rsp_rdy;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              ram_en;
   logic              ram_we;
   logic [3:0]        ram_wem;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic [31:0]       ram_dout;

   ram_lsu_port #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we), .req_addr(req_addr),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t        exp_q[$];
   int          accept_cyc[$];
   int          checks = 0;
   int          passed = 0;
   int          cyc = 0;
   logic [7:0]  ref_mem [NB];
   logic [31:0] ram [NW];
   logic [31:0] ram_init [NW];
   logic        load_ram = 1'b0;
   logic        op_we = 1'b0;
   logic [ADDR_W-1:0] op_addr = '0;
   logic [31:0] op_data = '0;
   int          rdy_mode = 0;
   logic        rdy_manual = 1'b1;

   // RAM port B model; dout is garbage whenever no read was issued
   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < NW; i++) ram[i] <= ram_init[i];
      end else if (op_we) begin
         ram[op_addr] <= op_data;
      end
      if (ram_en && ram_we) begin
         for (int i = 0; i < 4; i++)
            if (ram_wem[i]) ram[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
         ram_dout <= $urandom;
      end else if (ram_en) begin
         ram_dout <= ram[ram_addr];
      end else begin
         ram_dout <= $urandom;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0)      rsp_rdy = 1'b1;
      else if (rdy_mode == 1) rsp_rdy = ($urandom_range(0, 3) != 0);
      else                    rsp_rdy = rdy_manual;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      else
         passed++;
   endtask

   function automatic logic [31:0] ref_load(input int ba, input int n, input logic uns);
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[ba + i]) << (8 * i));
      if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   // runs at the negedge before the accepting posedge
   task automatic on_accept();
      int          n, ba, off;
      logic [3:0]  ewem;
      logic [31:0] lmask, edin;
      rsp_t        r;
      n   = 1 << req_size;
      ba  = int'(req_addr[ADDR_W+1:0]);
      off = ba % 4;
      accept_cyc.push_back(cyc);
      if (req_size == 2'd3 || (ba % n) != 0) begin
         chk("err_no_ram_en", ram_en, 0);
         r.rdata = 32'd0; r.err = 1'b1;
      end else if (req_we) begin
         ewem = '0; lmask = '0; edin = '0;
         for (int i = 0; i < n; i++) begin
            ewem[off + i]           = 1'b1;
            lmask[8*(off+i) +: 8]   = 8'hFF;
            edin[8*(off+i) +: 8]    = req_wdata[8*i +: 8];
            ref_mem[ba + i]         = req_wdata[8*i +: 8];
         end
         chk("st_ctl", {ram_en, ram_we, ram_wem}, {1'b1, 1'b1, ewem});
         chk("st_addr", ram_addr, ba / 4);
         chk("st_din", ram_din & lmask, edin);
         r.rdata = 32'd0; r.err = 1'b0;
      end else begin
         chk("ld_ctl", {ram_en, ram_we, ram_wem}, {1'b1, 1'b0, 4'b0000});
         chk("ld_addr", ram_addr, ba / 4);
         r.rdata = ref_load(ba, n, req_unsigned); r.err = 1'b0;
      end
      exp_q.push_back(r);
   endtask

   task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
      req_vld = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wdata;
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         if (req_rdy) begin
            on_accept();
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      chk("accept_timeout", 0, 1);
      req_vld = 1'b0;
   endtask

   task automatic idle();
      req_vld = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   logic        lat_pend = 1'b0;
   logic        stall_prev = 1'b0;
   logic [31:0] prev_rdata;
   logic        prev_err;

   always @(negedge clk) begin
      rsp_t r;
      if (!rst_n) begin
         lat_pend   = 1'b0;
         stall_prev = 1'b0;
      end else begin
         if (lat_pend) chk("latency_vld", rsp_vld, 1);
         if (stall_prev) chk("hold_stable", {rsp_vld, rsp_err, rsp_rdata}, {1'b1, prev_err, prev_rdata});
         if (rsp_vld && rsp_rdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               r = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, r.rdata);
               chk("rsp_err", rsp_err, r.err);
            end
         end
         lat_pend   = req_vld && req_rdy;
         stall_prev = rsp_vld && !rsp_rdy;
         prev_rdata = rsp_rdata;
         prev_err   = rsp_err;
      end
   end

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          r;
      rst_n = 1'b0; rsp_rdy = 1'b1;
      req_vld = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2;
      req_unsigned = 1'b0; req_wdata = 32'hFFFF_FFFF;
      for (int w = 0; w < NW; w++) begin
         ram_init[w] = $urandom;
         for (int b = 0; b < 4; b++) ref_mem[4*w + b] = ram_init[w][8*b +: 8];
      end
      @(posedge clk); #1 load_ram = 1'b1;
      @(posedge clk); #1 load_ram = 1'b0;
      @(negedge clk);
      chk("rst_ctl", {rsp_vld, rsp_err, ram_en, ram_we, ram_wem, req_rdy}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      req_vld = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_vld", rsp_vld, 0);

      // directed accesses, all back-to-back
      issue(1, 32'h10, 2, 0, 32'hA1B2_C3D4);
      issue(0, 32'h10, 2, 0, 0);
      issue(1, 32'h13, 0, 0, 32'h0000_005A);
      issue(0, 32'h13, 0, 0, 0);
      issue(0, 32'h10, 2, 0, 0);
      issue(1, 32'h11, 0, 0, 32'h0000_0080);
      issue(0, 32'h11, 0, 0, 0);
      issue(0, 32'h11, 0, 1, 0);
      issue(1, 32'h12, 1, 0, 32'h0000_8001);
      issue(0, 32'h12, 1, 0, 0);
      issue(0, 32'h12, 1, 1, 0);
      issue(0, 32'h11, 1, 0, 0);
      issue(0, 32'h10, 3, 0, 0);
      issue(1, 32'h21, 2, 0, 32'h1234_5678);
      idle();
      drain();

      // stalled response while the other port rewrites the word
      issue(1, 32'h40, 2, 0, 32'h1122_3344);
      idle();
      drain();
      rdy_manual = 1'b0; rdy_mode = 2;
      repeat (2) begin @(posedge clk); #1; end
      issue(0, 32'h40, 2, 0, 0);
      req_vld = 1'b0;
      op_addr = 8'h10; op_data = 32'hDEAD_BEEF; op_we = 1'b1;
      for (int b = 0; b < 4; b++) ref_mem[32'h40 + b] = op_data[8*b +: 8];
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k == 1) op_we = 1'b0;
         chk("stall_rdata", {rsp_vld, rsp_rdata}, {1'b1, 32'h1122_3344});
         chk("stall_req_rdy", req_rdy, 0);
         if (k == 2) rdy_manual = 1'b1;
      end
      @(posedge clk); #1;
      rdy_mode = 0;
      issue(0, 32'h40, 2, 0, 0);
      idle();
      drain();

      // back-to-back word loads
      accept_cyc.delete();
      for (int i = 0; i < 4; i++) issue(0, 32'h80 + 4 * i, 2, 0, 0);
      idle();
      drain();
      chk("b2b_span", accept_cyc[3] - accept_cyc[0], 3);

      // reset in the cycle after a load accept
      issue(0, 32'h20, 2, 0, 0);
      req_vld = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_vld", {rsp_vld, req_rdy}, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_quiet", rsp_vld, 0);
      end
      @(posedge clk); #1;
      issue(0, 32'h20, 2, 1, 0);
      idle();
      drain();

      // randomized traffic with a randomly stalling consumer
      rdy_mode = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         r  = $urandom_range(0, 9);
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         a  = $urandom & 32'hFFFF_FC3F;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         issue($urandom_range(0, 1) == 1, a, sz, $urandom_range(0, 1) == 1, $urandom);
      end
      idle();
      rdy_mode = 0;
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ram_lsu_port.md
Name: ram_lsu_port

Overview:
- Load/store initiator that drives one port of the byte-masked dual-port data RAM (1-cycle read latency, 4-bit byte write mask, separate enable and write strobes) on behalf of the core's LSU.
- Converts byte-addressed, size-qualified valid/ready requests into word-addressed RAM accesses, then returns aligned, sign/zero-extended responses on a valid/ready response channel.
- Sits between the LSU and RAM port B. At most one response is outstanding; throughput is one request per cycle when the response side is not stalled.

Parameters:
- ADDR_W, 16, RAM word-address width (RAM depth = 2^ADDR_W words of 32 bits).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_vld  input  1  request valid
- req_rdy  output  1  request ready
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  input  1  load zero-extend (1) / sign-extend (0)
- req_wdata  input  32  store data, LSB-justified
- rsp_vld  output  1  response valid
- rsp_rdy  input  1  response ready
- rsp_rdata  output  32  load data, extended; 0 for stores and errors
- rsp_err  output  1  misaligned or illegal-size access
- ram_en  output  1  RAM port enable
- ram_we  output  1  RAM port write enable
- ram_wem  output  4  RAM byte write mask
- ram_addr  output  ADDR_W  RAM word address
- ram_din  output  32  RAM write data
- ram_dout  input  32  RAM read data, valid the cycle after a read enable

Behaviour:
- Reset: all outputs deassert or clear while rst_n = 0 and on release.
  - Values: rsp_vld = 0, rsp_rdata = 0, rsp_err = 0, ram_en = 0, ram_we = 0, ram_wem = 0, req_rdy = 0; ram_addr/ram_din don't-care.
  - FSM returns to IDLE.
- Reset mid-operation: any pending response is discarded; no rsp_vld after rst_n rises until a new request is accepted.
- FSM states:
  - IDLE: no response pending.
  - RESP: response presented from live ram_dout, the cycle after acceptance.
  - HOLD: response presented from the capture register.
- req_rdy = rst_n & (state == IDLE | rsp_rdy). This is a combinational path from rsp_rdy; the consumer must not make rsp_rdy depend on req_rdy.
- Accept happens when req_vld & req_rdy.
  - On accept, register off = req_addr[1:0], size, unsigned, we, err.
  - Next state is RESP.
  - If there is no accept while a response is being consumed, next state is IDLE.
- Misaligned = (size == 1 & addr[0]) | (size == 2 & addr[1:0] != 0) | size == 3.
- RAM drive (combinational, in the accept cycle only):
  - ram_en = accept & ~misaligned.
  - ram_we = req_we.
  - ram_addr = req_addr[ADDR_W+1:2]; upper address bits are ignored.
- Store mask and data:
  - Byte: ram_wem = 4'b0001 << off; ram_din = {4{wdata[7:0]}}.
  - Half: ram_wem = 4'b0011 << off; ram_din = {2{wdata[15:0]}}.
  - Word: ram_wem = 4'b1111; ram_din = wdata.
  - ram_wem = 0 for loads.
- RESP (one cycle after accept): rsp_vld = 1.
  - Load rsp_rdata: shift ram_dout right by 8*off, take 8/16/32 bits, sign- or zero-extend per the registered unsigned flag.
  - Stores return rdata = 0. Errors return rdata = 0 and err = 1.
- RESP with rsp_rdy = 0: capture the formatted rdata and err into the hold register; next state is HOLD.
  - The response stays stable until rsp_rdy is sampled high (ram_dout is not relied on after RESP).
- HOLD: rsp_vld = 1 from the hold register.
- Consumption when rsp_rdy = 1 in RESP or HOLD:
  - The response completes.
  - A same-cycle new request is accepted (back-to-back), and the next state is RESP.
- rsp_vld, rsp_rdata and rsp_err never change while rsp_vld & ~rsp_rdy.
- Latency: response appears exactly 1 cycle after accept, for loads, stores and errors alike.

Test Plan:
- Word store addr 0x10, data 0xA1B2C3D4, then word load addr 0x10 -> store cycle: ram_en = 1, ram_we = 1, ram_wem = 4'hF, ram_addr = 4; load response 1 cycle later: rsp_rdata = 0xA1B2C3D4, rsp_err = 0.
- Byte store 0x5A to addr 0x13, then signed byte load addr 0x13 -> ram_wem = 4'b1000, ram_din = 0x5A5A5A5A; word at 0x10 reads 0x5AB2C3D4. Then store 0x80 to 0x11 -> signed byte load 0x11 returns 0xFFFFFF80; unsigned returns 0x00000080.
- Half load addr 0x12 signed with word 0x8001_xxxx -> rsp_rdata = 0xFFFF8001. Half load addr 0x11 -> rsp_err = 1, rdata = 0, ram_en never asserted. req_size = 3 -> rsp_err = 1.
- Load response with rsp_rdy held low 3 cycles while a RAM write on the other port changes the word -> rsp_rdata holds the original value all 3 cycles; req_rdy = 0 until rsp_rdy = 1.
- Back-to-back: 4 loads at consecutive words with rsp_rdy = 1 -> one accept per cycle, 4 responses in 4 consecutive cycles, each 1 cycle after its accept, in order.
- Assert rst_n = 0 in the cycle after a load accept -> rsp_vld = 0 immediately and stays 0 after release until a new request is accepted.
